// File: rtl/branch_outcome_tracker_pkg.sv
// Shared types and sizing helpers for the branch outcome tracker.
package branch_outcome_tracker_pkg;
  localparam int unsigned PC_W_DEF  = 9;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 32;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                pred;
  } entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_w(DEPTH_DEF);
endpackage

// File: rtl/branch_outcome_tracker_outcome_fifo.sv
// Circular buffer of outstanding predictions with push/pop/flush.
module branch_outcome_tracker_outcome_fifo
  import branch_outcome_tracker_pkg::*;
#(
  parameter int unsigned DATA_W = PC_W_DEF + 1,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              pop_ok,
  output logic              full,
  output logic              empty,
  output logic [OCC_W-1:0]  count
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              push_ok;

  assign full    = (count_q == OCC_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[head_q];

  // A pop frees a slot in the same edge, so a full queue still accepts a push alongside it.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_ok)  head_d = head_q + PTR_W'(1);
      if (push_ok) tail_d = tail_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= wr_data;
  end
endmodule

// File: rtl/branch_outcome_tracker.sv
// Tracks in-order branch resolution, emits registered BHT updates and accuracy stats.
module branch_outcome_tracker
  import branch_outcome_tracker_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [CNT_W-1:0]         total_predictions,
  output logic [CNT_W-1:0]         correct_predictions,
  output logic                     overflow,
  output logic                     underflow
);
  logic [PC_W:0]      rd_data;
  logic               pop_ok;
  logic               upd_valid_q, upd_valid_d;
  logic [PC_W-1:0]    upd_pc_q, upd_pc_d;
  logic               upd_taken_q, upd_taken_d;
  logic               mispredict_q, mispredict_d;
  logic [CNT_W-1:0]   total_q, total_d, correct_q, correct_d;
  logic               overflow_q, overflow_d, underflow_q, underflow_d;

  branch_outcome_tracker_outcome_fifo #(
    .DATA_W (PC_W + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (pred_valid),
    .pop     (resolve_valid),
    .flush   (flush),
    .wr_data ({pred_pc, pred_taken}),
    .rd_data (rd_data),
    .pop_ok  (pop_ok),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    upd_valid_d  = 1'b0;
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;
    mispredict_d = mispredict_q;
    total_d      = total_q;
    correct_d    = correct_q;
    if (pop_ok) begin
      upd_valid_d  = 1'b1;
      upd_pc_d     = rd_data[PC_W:1];
      upd_taken_d  = resolve_taken;
      mispredict_d = (rd_data[0] != resolve_taken);
      total_d      = total_q + CNT_W'(1);
      if (rd_data[0] == resolve_taken) correct_d = correct_q + CNT_W'(1);
    end
    // Flush suppresses both error conditions along with the discarded push/pop.
    overflow_d  = overflow_q  | (!flush && pred_valid && full && !pop_ok);
    underflow_d = underflow_q | (!flush && resolve_valid && empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      total_q      <= '0;
      correct_q    <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      total_q      <= total_d;
      correct_q    <= correct_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign upd_valid           = upd_valid_q;
  assign upd_pc              = upd_pc_q;
  assign upd_taken           = upd_taken_q;
  assign mispredict          = mispredict_q;
  assign total_predictions   = total_q;
  assign correct_predictions = correct_q;
  assign overflow            = overflow_q;
  assign underflow           = underflow_q;
endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_branch_outcome_tracker;
  import branch_outcome_tracker_pkg::*;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pred_valid = 1'b0;
  logic [PC_W-1:0]   pred_pc = '0;
  logic              pred_taken = 1'b0;
  logic              resolve_valid = 1'b0;
  logic              resolve_taken = 1'b0;
  logic              flush = 1'b0;
  logic              full, empty;
  logic [$clog2(DEPTH):0] count;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken, mispredict;
  logic [CNT_W-1:0]  total_predictions, correct_predictions;
  logic              overflow, underflow;

  branch_outcome_tracker #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pred_valid          (pred_valid),
    .pred_pc             (pred_pc),
    .pred_taken          (pred_taken),
    .resolve_valid       (resolve_valid),
    .resolve_taken       (resolve_taken),
    .flush               (flush),
    .full                (full),
    .empty               (empty),
    .count               (count),
    .upd_valid           (upd_valid),
    .upd_pc              (upd_pc),
    .upd_taken           (upd_taken),
    .mispredict          (mispredict),
    .total_predictions   (total_predictions),
    .correct_predictions (correct_predictions),
    .overflow            (overflow),
    .underflow           (underflow)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  entry_t          mq[$];
  bit              m_upd_valid, m_upd_taken, m_mis, m_over, m_under;
  logic [PC_W-1:0] m_upd_pc;
  int unsigned     m_total, m_correct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_upd_valid = 0; m_upd_taken = 0; m_mis = 0; m_over = 0; m_under = 0;
    m_upd_pc = '0; m_total = 0; m_correct = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ":count"},     32'(count),             32'(mq.size()));
    chk({where, ":full"},      32'(full),              32'(mq.size() == DEPTH));
    chk({where, ":empty"},     32'(empty),             32'(mq.size() == 0));
    chk({where, ":upd_valid"}, 32'(upd_valid),         32'(m_upd_valid));
    chk({where, ":upd_pc"},    32'(upd_pc),            32'(m_upd_pc));
    chk({where, ":upd_taken"}, 32'(upd_taken),         32'(m_upd_taken));
    chk({where, ":mispred"},   32'(mispredict),        32'(m_mis));
    chk({where, ":total"},     total_predictions,      m_total);
    chk({where, ":correct"},   correct_predictions,    m_correct);
    chk({where, ":overflow"},  32'(overflow),          32'(m_over));
    chk({where, ":underflow"}, 32'(underflow),         32'(m_under));
  endtask

  // Drive one cycle of inputs, advance the model by the stated rules, then compare.
  task automatic step(input string where, input bit pv, input logic [PC_W-1:0] pc,
                      input bit pt, input bit rv, input bit rt, input bit fl);
    entry_t e;
    bit popped;
    pred_valid = pv; pred_pc = pc; pred_taken = pt;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_upd_valid = 0;
    end else begin
      popped = 0;
      if (rv) begin
        if (mq.size() == 0) m_under = 1;
        else begin
          e = mq.pop_front();
          popped = 1;
          m_upd_pc = e.pc; m_upd_taken = rt; m_mis = (e.pred != rt);
          m_total++;
          if (!m_mis) m_correct++;
        end
      end
      m_upd_valid = popped;
      if (pv) begin
        if (mq.size() < DEPTH) begin
          e.pc = pc; e.pred = pt;
          mq.push_back(e);
        end else m_over = 1;
      end
    end
    #1;
    check_all(where);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string where);
    pred_valid = 0; resolve_valid = 0; flush = 0;
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_all(where);
    #3 reset = 1'b1;
  endtask

  initial begin
    model_clear();
    #2;
    check_all("por");
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check_all("post_release");

    // Reset in the middle of operation
    step("rm_push0", 1, 9'd1, 1, 0, 0, 0);
    step("rm_push1", 1, 9'd2, 0, 0, 0, 0);
    step("rm_push2", 1, 9'd3, 1, 0, 0, 0);
    async_reset("mid_reset");

    // In-order resolve
    step("io_p0", 1, 9'd5, 1, 0, 0, 0);
    step("io_p1", 1, 9'd9, 0, 0, 0, 0);
    step("io_p2", 1, 9'd5, 0, 0, 0, 0);
    step("io_r0", 0, '0, 0, 1, 1, 0);
    chk("io_r0_pc", 32'(upd_pc), 32'd5);
    chk("io_r0_mis", 32'(mispredict), 32'd0);
    step("io_r1", 0, '0, 0, 1, 1, 0);
    chk("io_r1_pc", 32'(upd_pc), 32'd9);
    chk("io_r1_mis", 32'(mispredict), 32'd1);
    step("io_r2", 0, '0, 0, 1, 0, 0);
    chk("io_r2_pc", 32'(upd_pc), 32'd5);
    chk("io_total", total_predictions, 32'd3);
    chk("io_correct", correct_predictions, 32'd2);
    step("io_idle", 0, '0, 0, 0, 0, 0);

    // Full boundary
    for (int i = 0; i < 8; i++) step("fb_fill", 1, 9'(16 + i), i[0], 0, 0, 0);
    chk("fb_full", 32'(full), 32'd1);
    step("fb_over", 1, 9'd100, 1, 0, 0, 0);
    chk("fb_over_flag", 32'(overflow), 32'd1);
    chk("fb_over_cnt", 32'(count), 32'd8);
    step("fb_pushpop", 1, 9'd101, 1, 1, 1, 0);
    chk("fb_pp_cnt", 32'(count), 32'd8);
    chk("fb_pp_updv", 32'(upd_valid), 32'd1);
    for (int i = 0; i < 8; i++) step("fb_drain", 0, '0, 0, 1, i[1], 0);

    // Empty boundary with no bypass
    step("eb_respush", 1, 9'd77, 1, 1, 1, 0);
    chk("eb_under", 32'(underflow), 32'd1);
    chk("eb_updv", 32'(upd_valid), 32'd0);
    chk("eb_cnt", 32'(count), 32'd1);
    step("eb_pop", 0, '0, 0, 1, 1, 0);

    // Flush with simultaneous push and resolve
    for (int i = 0; i < 4; i++) step("fl_fill", 1, 9'(40 + i), 1, 0, 0, 0);
    step("fl_flush", 1, 9'd50, 1, 1, 1, 1);
    chk("fl_cnt", 32'(count), 32'd0);
    step("fl_push", 1, 9'd60, 0, 0, 0, 0);
    step("fl_pop", 0, '0, 0, 1, 0, 0);
    chk("fl_pop_pc", 32'(upd_pc), 32'd60);

    // Wrap-around from a clean reset
    async_reset("wrap_reset");
    for (int i = 0; i < 20; i++) begin
      step("wr_push", 1, 9'(200 + i), 1, 0, 0, 0);
      step("wr_pop", 0, '0, 0, 1, ~i[0], 0);
      chk("wr_pc", 32'(upd_pc), 32'(200 + i));
    end
    chk("wr_total", total_predictions, 32'd20);
    chk("wr_correct", correct_predictions, 32'd10);

    // Random traffic
    async_reset("rand_reset");
    for (int i = 0; i < 400; i++) begin
      step("rand", bit'($urandom_range(0, 99) < 55), 9'($urandom), bit'($urandom),
           bit'($urandom_range(0, 99) < 45), bit'($urandom),
           bit'($urandom_range(0, 99) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_outcome_tracker.md
Name: branch_outcome_tracker

Overview:
Downstream companion of the branch history table. Queues each issued prediction (PC index plus predicted direction) until the branch resolves in order. On resolution it compares the stored prediction with the actual outcome and emits a registered update to the BHT (PC, taken). It also maintains prediction-accuracy statistics and sticky error flags.

Parameters:
PC_W, 9, width of PC index carried with each prediction (matches BHT pc input)
DEPTH, 8, outstanding-branch queue entries; power of two, >= 2
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
pred_valid  in  1  new prediction issued this cycle
pred_pc  in  PC_W  PC index of predicted branch
pred_taken  in  1  BHT prediction for that branch
resolve_valid  in  1  oldest outstanding branch resolves this cycle
resolve_taken  in  1  actual outcome of oldest branch
flush  in  1  discard all outstanding entries (pipeline squash)
full  out  1  queue holds DEPTH entries
empty  out  1  queue holds 0 entries
count  out  $clog2(DEPTH)+1  current occupancy
upd_valid  out  1  BHT update strobe, one cycle
upd_pc  out  PC_W  PC index to update
upd_taken  out  1  actual outcome to train with
mispredict  out  1  valid with upd_valid; stored prediction != outcome
total_predictions  out  CNT_W  resolved branches
correct_predictions  out  CNT_W  resolved branches predicted correctly
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: resolve attempted while empty

Behaviour:
- Reset (reset=0, async): queue empty; head/tail pointers 0; count=0; empty=1; full=0; upd_valid=0; upd_pc=0; upd_taken=0; mispredict=0; both counters 0; overflow=0; underflow=0. Outputs remain at these values until the first rising edge after reset deasserts.
- Storage: circular buffer of {pc, pred_taken}. Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by the count register. full = (count==DEPTH); empty = (count==0).
- Push: on a rising edge with pred_valid=1 and either not full or pop in the same cycle, write to tail and advance tail.
- Pop: on a rising edge with resolve_valid=1 and not empty, read head, advance head, and register outputs. Latency is 1 cycle: upd_valid=1 in the next cycle, with upd_pc=head.pc, upd_taken=resolve_taken, mispredict=(head.pred != resolve_taken). When no pop occurs, upd_valid=0 and the other update outputs hold their last values.
- Counters: each pop increments total_predictions by 1, and correct_predictions by 1 if not mispredict. Counters update in the same edge as the upd_* registers and wrap modulo 2^CNT_W.
- Simultaneous push+pop: both occur and count is unchanged. When full, this is legal and no overflow is flagged.
- Push while full without a pop: the entry is dropped, overflow is set, and the queue is unchanged.
- Resolve while empty: ignored, underflow is set, and upd_valid stays 0. There is no bypass: a push in the same cycle does not satisfy a resolve on an empty queue.
- Flush: highest priority. It zeroes pointers and count. Any same-cycle push or pop is discarded; upd_valid=0 next cycle; counters and sticky flags are unchanged.
- Sticky flags clear only on reset.
- The count output equals the registered count; no combinational path runs from inputs to full, empty or count.

Decomposition:
- Shared package: queue entry struct {pc[PC_W], pred}, and a DEPTH-derived pointer-width constant.
- One sub-module is natural: outcome_fifo (circular buffer with push/pop/flush and full/empty/count). The top level holds the compare logic, update register, counters and sticky flags.

Test Plan:
- Reset mid-operation: push 3 entries, assert reset=0 asynchronously between edges -> count=0, empty=1, counters=0, upd_valid=0 immediately.
- In-order resolve: push (pc=5,T), (pc=9,NT), (pc=5,NT); resolve T,T,NT -> upd pulses pc=5/9/5 with upd_taken=1/1/0 and mispredict=0/1/0; total=3, correct=2.
- Full boundary, DEPTH=8: push 8 -> full=1. Push a 9th alone -> overflow=1, count=8. Push+resolve together -> count=8, overflow unchanged, upd_valid=1.
- Empty boundary: resolve on an empty queue with a same-cycle push -> underflow=1, upd_valid=0 next cycle, count=1.
- Flush: push 4, then flush with simultaneous resolve -> count=0, upd_valid=0, total unchanged. Next push and resolve use pointer 0.
- Wrap-around: 20 push/resolve pairs with alternating outcomes and all predictions T -> total=20, correct=10, each upd_pc matches its pushed pc in order.
